alram_arb2: RTL and testbench

//  Two-master round-robin arbiter and sequencer in front of one simple dual-port RAM (alram113x class).

---
 rtl/alram_arb2_if.sv | 26 ++
 rtl/alram_arb2.sv | 104 ++++++++++
 tb/tb_alram_arb2.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alram_arb2_if.sv
// Master-side bundle for alram_arb2: one write channel and one read channel
// with combinational grants and tagged read returns.
interface alram_arb2_if #(
    parameter int WID  = 256,
    parameter int AWID = 5
);
    logic            wreq;
    logic [AWID-1:0] wa;
    logic [WID-1:0]  wdi;
    logic            wgnt;
    logic            rreq;
    logic [AWID-1:0] ra;
    logic            rgnt;
    logic            rvld;
    logic [WID-1:0]  rdo;

    modport master (
        output wreq, wa, wdi, rreq, ra,
        input  wgnt, rgnt, rvld, rdo
    );

    modport slave (
        input  wreq, wa, wdi, rreq, ra,
        output wgnt, rgnt, rvld, rdo
    );
endinterface

// File: rtl/alram_arb2.sv
// Two-master round-robin arbiter in front of a simple dual-port RAM.
// Write and read ports arbitrate independently; reads yield to same-address writes.
module alram_arb2 #(
    parameter int WID  = 256,
    parameter int AWID = 5,
    parameter int RLAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    alram_arb2_if.slave      m0,
    alram_arb2_if.slave      m1,
    output logic             ram_we_o,
    output logic [AWID-1:0]  ram_wa_o,
    output logic [WID-1:0]   ram_wdi_o,
    output logic [AWID-1:0]  ram_ra_o,
    input  logic [WID-1:0]   ram_rdo_i
);

    logic            wptr_q, wptr_d;
    logic            rptr_q, rptr_d;
    logic            ram_we_q, ram_we_d;
    logic [AWID-1:0] ram_wa_q, ram_wa_d;
    logic [WID-1:0]  ram_wdi_q, ram_wdi_d;
    logic [AWID-1:0] ram_ra_q, ram_ra_d;
    logic [RLAT:0]   pvld_q, pvld_d;
    logic [RLAT:0]   pid_q, pid_d;

    logic            w_any, w_sel;
    logic            r_any, r_sel, r_hit, r_go;
    logic [AWID-1:0] w_addr, r_addr;
    logic [WID-1:0]  w_data;

    // Pointer value names the master favoured when both request
    always_comb begin
        w_any  = m0.wreq | m1.wreq;
        w_sel  = (m0.wreq & m1.wreq) ? wptr_q : m1.wreq;
        w_addr = w_sel ? m1.wa : m0.wa;
        w_data = w_sel ? m1.wdi : m0.wdi;

        r_any  = m0.rreq | m1.rreq;
        r_sel  = (m0.rreq & m1.rreq) ? rptr_q : m1.rreq;
        r_addr = r_sel ? m1.ra : m0.ra;
        r_hit  = w_any & r_any & (r_addr == w_addr);
        r_go   = r_any & ~r_hit;

        wptr_d = w_any ? ~w_sel : wptr_q;
        rptr_d = r_go ? ~r_sel : rptr_q;
    end

    always_comb begin
        ram_we_d  = w_any;
        ram_wa_d  = ram_wa_q;
        ram_wdi_d = ram_wdi_q;
        ram_ra_d  = ram_ra_q;
        if (w_any) begin
            ram_wa_d  = w_addr;
            ram_wdi_d = w_data;
        end
        if (r_go) begin
            ram_ra_d = r_addr;
        end
        pvld_d = {pvld_q[RLAT-1:0], r_go};
        pid_d  = {pid_q[RLAT-1:0], r_sel};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            ram_we_q  <= 1'b0;
            ram_wa_q  <= '0;
            ram_wdi_q <= '0;
            ram_ra_q  <= '0;
            pvld_q    <= '0;
            pid_q     <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_we_q  <= ram_we_d;
            ram_wa_q  <= ram_wa_d;
            ram_wdi_q <= ram_wdi_d;
            ram_ra_q  <= ram_ra_d;
            pvld_q    <= pvld_d;
            pid_q     <= pid_d;
        end
    end

    assign m0.wgnt = w_any & ~w_sel;
    assign m1.wgnt = w_any & w_sel;
    assign m0.rgnt = r_go & ~r_sel;
    assign m1.rgnt = r_go & r_sel;

    // Last pipeline stage lines up with the RAM's read data
    assign m0.rvld = pvld_q[RLAT] & ~pid_q[RLAT];
    assign m1.rvld = pvld_q[RLAT] & pid_q[RLAT];
    assign m0.rdo  = ram_rdo_i;
    assign m1.rdo  = ram_rdo_i;

    assign ram_we_o  = ram_we_q;
    assign ram_wa_o  = ram_wa_q;
    assign ram_wdi_o = ram_wdi_q;
    assign ram_ra_o  = ram_ra_q;

endmodule

// File: tb/tb_alram_arb2.sv
// Bench for alram_arb2: directed grant table, corner sequences and
// random traffic against a cycle-level arbitration/memory model.
module tb_alram_arb2;
    localparam int WID  = 256;
    localparam int AWID = 5;
    localparam int RLAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alram_arb2_if #(.WID(WID), .AWID(AWID)) m0_if ();
    alram_arb2_if #(.WID(WID), .AWID(AWID)) m1_if ();

    logic            ram_we;
    logic [AWID-1:0] ram_wa, ram_ra;
    logic [WID-1:0]  ram_wdi, ram_rdo;

    alram_arb2 #(.WID(WID), .AWID(AWID), .RLAT(RLAT)) dut (
        .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
        .ram_we_o(ram_we), .ram_wa_o(ram_wa), .ram_wdi_o(ram_wdi),
        .ram_ra_o(ram_ra), .ram_rdo_i(ram_rdo)
    );

    logic [WID-1:0] ram_mem [1<<AWID];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_wa] <= ram_wdi;
        ram_rdo <= ram_mem[ram_ra];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [WID-1:0] act,
                       input logic [WID-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int             due;
        int             id;
        logic [WID-1:0] d;
        bit             known;
    } ret_t;

    ret_t            q[$];
    logic [WID-1:0]  mm [1<<AWID];
    bit              wr_ok [1<<AWID];
    int              wlast = 1;
    int              rlast = 1;
    logic            exp_we = 1'b0;
    logic [AWID-1:0] exp_wa = '0;
    logic [WID-1:0]  exp_wdi = '0;
    logic [AWID-1:0] exp_ra = '0;

    function automatic int pick(bit a, bit b, int last);
        if (a && b) return (last == 0) ? 1 : 0;
        if (a) return 0;
        if (b) return 1;
        return -1;
    endfunction

    always @(negedge clk) begin
        int ww, rw;
        logic [AWID-1:0] wa_w, ra_w;
        logic [WID-1:0] wd_w;
        logic e0, e1;
        if (rst) begin
            q.delete();
            wlast = 1; rlast = 1;
            exp_we = 0; exp_wa = '0; exp_wdi = '0; exp_ra = '0;
            chk("rst_we", ram_we, 0);
            chk("rst_rvld", {m0_if.rvld, m1_if.rvld}, 0);
        end else begin
            ww = pick(m0_if.wreq, m1_if.wreq, wlast);
            rw = pick(m0_if.rreq, m1_if.rreq, rlast);
            wa_w = (ww == 1) ? m1_if.wa : m0_if.wa;
            wd_w = (ww == 1) ? m1_if.wdi : m0_if.wdi;
            ra_w = (rw == 1) ? m1_if.ra : m0_if.ra;
            if (ww >= 0 && rw >= 0 && ra_w == wa_w) rw = -1;
            chk("m_grants", {m0_if.wgnt, m1_if.wgnt, m0_if.rgnt, m1_if.rgnt},
                {ww == 0, ww == 1, rw == 0, rw == 1});
            chk("m_ram_we", ram_we, exp_we);
            chk("m_ram_wa", ram_wa, exp_wa);
            chk("m_ram_wdi", ram_wdi, exp_wdi);
            chk("m_ram_ra", ram_ra, exp_ra);
            while (q.size() > 0 && q[0].due < cyc) begin
                checks++; errors++;
                $display("FAIL rvld_missing @%0d: got none expected id %0d", cyc, q[0].id);
                void'(q.pop_front());
            end
            e0 = q.size() > 0 && q[0].due == cyc && q[0].id == 0;
            e1 = q.size() > 0 && q[0].due == cyc && q[0].id == 1;
            chk("m_rvld", {m0_if.rvld, m1_if.rvld}, {e0, e1});
            if (e0 || e1) begin
                if (q[0].known) chk("m_rdo", e0 ? m0_if.rdo : m1_if.rdo, q[0].d);
                void'(q.pop_front());
            end
            if (rw >= 0) begin
                q.push_back('{cyc + 1 + RLAT, rw, mm[ra_w], wr_ok[ra_w]});
                exp_ra = ra_w;
                rlast = rw;
            end
            if (ww >= 0) begin
                mm[wa_w] = wd_w; wr_ok[wa_w] = 1'b1;
                exp_we = 1; exp_wa = wa_w; exp_wdi = wd_w;
                wlast = ww;
            end else begin
                exp_we = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        bit w0, w1, r0, r1;
        logic [AWID-1:0] wa0, wa1, ra0, ra1;
        logic [3:0] g;
    } vec_t;

    function automatic vec_t mk(bit w0, bit w1, bit r0, bit r1,
                                int wa0, int wa1, int ra0, int ra1,
                                logic [3:0] g);
        vec_t v;
        v.w0 = w0; v.w1 = w1; v.r0 = r0; v.r1 = r1;
        v.wa0 = AWID'(wa0); v.wa1 = AWID'(wa1);
        v.ra0 = AWID'(ra0); v.ra1 = AWID'(ra1);
        v.g = g;
        return v;
    endfunction

    function automatic logic [WID-1:0] dval(logic [AWID-1:0] a);
        return WID'(a) * 100 + 30;
    endfunction

    task automatic idle();
        m0_if.wreq = 0; m1_if.wreq = 0;
        m0_if.rreq = 0; m1_if.rreq = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic wait_rvld(input bit id, output int n);
        n = 1;
        @(negedge clk);
        while (!(id ? m1_if.rvld : m0_if.rvld) && n < 8) begin
            n++;
            @(negedge clk);
        end
    endtask

    vec_t tv[11];

    initial begin
        int n, cnt;
        bit g0w, g1w, g0r, g1r;
        tv[0]  = mk(1, 0, 0, 0, 12, 0, 0, 0, 4'b1000);
        tv[1]  = mk(1, 1, 0, 0, 3, 4, 0, 0, 4'b0100);
        tv[2]  = mk(1, 1, 0, 0, 3, 5, 0, 0, 4'b1000);
        tv[3]  = mk(0, 0, 1, 1, 0, 0, 5, 6, 4'b0010);
        tv[4]  = mk(0, 0, 1, 1, 0, 0, 7, 6, 4'b0001);
        tv[5]  = mk(1, 0, 1, 1, 7, 0, 7, 8, 4'b1000);
        tv[6]  = mk(0, 0, 1, 1, 0, 0, 7, 8, 4'b0010);
        tv[7]  = mk(0, 1, 1, 1, 0, 9, 9, 8, 4'b0101);
        tv[8]  = mk(1, 1, 1, 1, 10, 11, 9, 10, 4'b1010);
        tv[9]  = mk(0, 1, 0, 1, 0, 11, 0, 10, 4'b0101);
        tv[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);

        idle();
        m0_if.wa = '0; m1_if.wa = '0; m0_if.ra = '0; m1_if.ra = '0;
        m0_if.wdi = '0; m1_if.wdi = '0;

        // reset then idle
        do_reset();
        repeat (10) begin
            @(negedge clk);
            chk("idle_out", {ram_we, ram_wa, ram_wdi, ram_ra, m0_if.rvld, m1_if.rvld,
                             m0_if.wgnt, m1_if.wgnt, m0_if.rgnt, m1_if.rgnt}, 0);
            tick();
        end

        // directed grant table
        do_reset();
        for (int i = 0; i < 11; i++) begin
            m0_if.wreq = tv[i].w0; m1_if.wreq = tv[i].w1;
            m0_if.rreq = tv[i].r0; m1_if.rreq = tv[i].r1;
            m0_if.wa = tv[i].wa0; m1_if.wa = tv[i].wa1;
            m0_if.wdi = dval(tv[i].wa0); m1_if.wdi = dval(tv[i].wa1);
            m0_if.ra = tv[i].ra0; m1_if.ra = tv[i].ra1;
            @(negedge clk);
            chk($sformatf("tbl%0d", i),
                {m0_if.wgnt, m1_if.wgnt, m0_if.rgnt, m1_if.rgnt}, tv[i].g);
            tick();
        end
        idle();
        repeat (3) tick();

        // write 12/1230 then read it back
        do_reset();
        m0_if.wreq = 1; m0_if.wa = 12; m0_if.wdi = 1230;
        @(negedge clk);
        chk("t2_wgnt", m0_if.wgnt, 1);
        tick();
        m0_if.wreq = 0;
        @(negedge clk);
        chk("t2_ram_w", {ram_we, ram_wa, ram_wdi}, {1'b1, 5'd12, 256'd1230});
        tick();
        m0_if.rreq = 1; m0_if.ra = 12;
        @(negedge clk);
        chk("t2_rgnt", m0_if.rgnt, 1);
        tick();
        m0_if.rreq = 0;
        wait_rvld(0, n);
        chk("t2_lat", n, 2);
        chk("t2_rdo", m0_if.rdo, 1230);
        tick();

        // both masters write for 6 cycles from reset
        do_reset();
        m0_if.wreq = 1; m0_if.wa = 1; m0_if.wdi = 11;
        m1_if.wreq = 1; m1_if.wa = 2; m1_if.wdi = 22;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("t3_alt%0d", i), {m0_if.wgnt, m1_if.wgnt},
                (i % 2 == 0) ? 2'b10 : 2'b01);
            tick();
        end
        idle();

        // write 13 and read 13 collide
        m0_if.wreq = 1; m0_if.wa = 13; m0_if.wdi = 1330;
        m1_if.rreq = 1; m1_if.ra = 13;
        @(negedge clk);
        chk("t4_block", {m0_if.wgnt, m1_if.rgnt}, 2'b10);
        tick();
        m0_if.wreq = 0;
        @(negedge clk);
        chk("t4_retry", m1_if.rgnt, 1);
        tick();
        m1_if.rreq = 0;
        wait_rvld(1, n);
        chk("t4_rdo", {m1_if.rvld, m1_if.rdo}, {1'b1, 256'd1330});
        tick();

        // both masters read held together
        m0_if.rreq = 1; m0_if.ra = 12;
        m1_if.rreq = 1; m1_if.ra = 13;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("t5_alt%0d", i), {m0_if.rgnt, m1_if.rgnt},
                (i % 2 == 0) ? 2'b10 : 2'b01);
            chk("t5_excl", m0_if.rvld & m1_if.rvld, 0);
            tick();
        end
        idle();
        repeat (4) begin
            @(negedge clk);
            chk("t5_excl", m0_if.rvld & m1_if.rvld, 0);
            tick();
        end

        // reset while a read is in flight
        do_reset();
        m0_if.rreq = 1; m0_if.ra = 12;
        @(negedge clk);
        chk("t6_rgnt", m0_if.rgnt, 1);
        tick();
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (m0_if.rvld || m1_if.rvld) cnt++;
            tick();
        end
        chk("t6_norvld", cnt, 0);
        m0_if.wreq = 1; m0_if.wa = 1; m1_if.wreq = 1; m1_if.wa = 2;
        m0_if.rreq = 1; m0_if.ra = 3; m1_if.rreq = 1; m1_if.ra = 4;
        @(negedge clk);
        chk("t6_prio", {m0_if.wgnt, m1_if.wgnt, m0_if.rgnt, m1_if.rgnt}, 4'b1010);
        tick();
        idle();

        // random traffic, masters hold requests until granted
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            g0w = m0_if.wgnt; g1w = m1_if.wgnt;
            g0r = m0_if.rgnt; g1r = m1_if.rgnt;
            tick();
            if (!m0_if.wreq || g0w) begin
                m0_if.wreq = 1'($urandom_range(0, 1));
                m0_if.wa = AWID'($urandom_range(0, 3));
                m0_if.wdi = {8{$urandom}};
            end
            if (!m1_if.wreq || g1w) begin
                m1_if.wreq = 1'($urandom_range(0, 1));
                m1_if.wa = AWID'($urandom_range(0, 3));
                m1_if.wdi = {8{$urandom}};
            end
            if (!m0_if.rreq || g0r) begin
                m0_if.rreq = 1'($urandom_range(0, 1));
                m0_if.ra = AWID'($urandom_range(0, 3));
            end
            if (!m1_if.rreq || g1r) begin
                m1_if.rreq = 1'($urandom_range(0, 1));
                m1_if.ra = AWID'($urandom_range(0, 3));
            end
        end
        idle();
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
